// File: rtl/clock_set_ctrl.sv
// Mode/set controller for the HH:MM:SS clock: gates counter enables, runs the time-set FSM and field blink.
// Define CLOCK_SET_AUTO_REPEAT_EN to build auto-repeat of a held btn_inc in the SET states.
module clock_set_ctrl #(
    parameter int unsigned BLINK_DIV     = 25_000_000,
    parameter int unsigned TIMEOUT_TICKS = 10
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY  = 50_000_000,
    parameter int unsigned REPEAT_DIV    = 10_000_000
`endif
) (
    input  logic       clk,
    input  logic       glob_rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_carry,
    input  logic       min_carry,
    output logic       ce_sec,
    output logic       ce_min,
    output logic       ce_hour,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic [2:0] blank
);

    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned IDLE_W  = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {
        S_RUN      = 2'b00,
        S_SET_HOUR = 2'b01,
        S_SET_MIN  = 2'b10,
        S_SET_SEC  = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic                btn_mode_q, btn_mode_prev_q;
    logic                btn_inc_q, btn_inc_prev_q;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_ph_q, blink_ph_d;

    logic mode_edge, inc_edge, inc_pulse, rpt_pulse;
    logic in_set, timeout, state_chg;

    assign mode_edge = btn_mode_q & ~btn_mode_prev_q;
    assign inc_edge  = btn_inc_q & ~btn_inc_prev_q;
    assign inc_pulse = inc_edge | rpt_pulse;
    assign in_set    = (state_q != S_RUN);

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_DIV) ? REPEAT_DELAY : REPEAT_DIV;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_armed_q, rpt_armed_d;

    // First repeat after REPEAT_DELAY held cycles, then every REPEAT_DIV cycles.
    assign rpt_pulse = btn_inc_q & in_set &
                       (rpt_armed_q ? (rpt_cnt_q == RPT_W'(REPEAT_DIV))
                                    : (rpt_cnt_q == RPT_W'(REPEAT_DELAY)));

    always_comb begin
        rpt_cnt_d   = rpt_cnt_q + RPT_W'(1);
        rpt_armed_d = rpt_armed_q;
        if (!(btn_inc_q && in_set) || state_chg) begin
            rpt_cnt_d   = '0;
            rpt_armed_d = 1'b0;
        end else if (rpt_pulse) begin
            rpt_cnt_d   = RPT_W'(1);
            rpt_armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (glob_rst) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign rpt_pulse = 1'b0;
`endif

    // A button edge on the timeout tick wins over the timeout.
    assign timeout = in_set & tick_1hz & ~mode_edge & ~inc_pulse &
                     (idle_q == IDLE_W'(TIMEOUT_TICKS - 1));

    always_comb begin
        state_d = state_q;
        if (mode_edge) begin
            unique case (state_q)
                S_RUN:      state_d = S_SET_HOUR;
                S_SET_HOUR: state_d = S_SET_MIN;
                S_SET_MIN:  state_d = S_SET_SEC;
                S_SET_SEC:  state_d = S_RUN;
                default:    state_d = S_RUN;
            endcase
        end else if (timeout) begin
            state_d = S_RUN;
        end
    end

    assign state_chg = (state_d != state_q);

    always_comb begin
        idle_d = idle_q;
        if (!in_set || mode_edge || inc_pulse || state_chg) begin
            idle_d = '0;
        end else if (tick_1hz) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        blink_ph_d  = blink_ph_q;
        if (state_chg) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end
    end

    always_comb begin
        ce_sec  = 1'b0;
        ce_min  = 1'b0;
        ce_hour = 1'b0;
        sec_clr = 1'b0;
        blank   = 3'b000;
        unique case (state_q)
            S_RUN: begin
                ce_sec  = tick_1hz;
                ce_min  = sec_carry;
                ce_hour = min_carry;
            end
            S_SET_HOUR: begin
                ce_hour  = inc_pulse;
                blank[2] = blink_ph_q;
            end
            S_SET_MIN: begin
                ce_min   = inc_pulse;
                blank[1] = blink_ph_q;
            end
            S_SET_SEC: begin
                sec_clr  = inc_pulse;
                blank[0] = blink_ph_q;
            end
            default: ;
        endcase
    end

    assign mode = state_q;

    always_ff @(posedge clk) begin
        if (glob_rst) begin
            state_q         <= S_RUN;
            btn_mode_q      <= 1'b0;
            btn_mode_prev_q <= 1'b0;
            btn_inc_q       <= 1'b0;
            btn_inc_prev_q  <= 1'b0;
            idle_q          <= '0;
            blink_cnt_q     <= '0;
            blink_ph_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            btn_mode_q      <= btn_mode;
            btn_mode_prev_q <= btn_mode_q;
            btn_inc_q       <= btn_inc;
            btn_inc_prev_q  <= btn_inc_q;
            idle_q          <= idle_d;
            blink_cnt_q     <= blink_cnt_d;
            blink_ph_q      <= blink_ph_d;
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (BLINK_DIV=4, TIMEOUT_TICKS=3).
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       glob_rst = 1'b1;
    logic       tick_1hz = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0;
    logic       sec_carry = 1'b0, min_carry = 1'b0;
    logic       ce_sec, ce_min, ce_hour, sec_clr;
    logic [1:0] mode;
    logic [2:0] blank;
    int         total = 0;
    int         bad = 0;

    clock_set_ctrl #(
        .BLINK_DIV(4),
        .TIMEOUT_TICKS(3)
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        ,
        .REPEAT_DELAY(8),
        .REPEAT_DIV(4)
`endif
    ) dut (
        .clk(clk), .glob_rst(glob_rst), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc),
        .sec_carry(sec_carry), .min_carry(min_carry),
        .ce_sec(ce_sec), .ce_min(ce_min), .ce_hour(ce_hour),
        .sec_clr(sec_clr), .mode(mode), .blank(blank)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cyc();
        btn_mode = 1'b0;
        cyc();
    endtask

    task automatic test_reset();
        glob_rst = 1'b1;
        cyc();
        cyc();
        total++; if (mode !== 2'b00) begin bad++; $display("FAIL reset_mode got=%b exp=00", mode); end
        total++; if (blank !== 3'b000) begin bad++; $display("FAIL reset_blank got=%b exp=000", blank); end
        total++; if ({ce_sec, ce_min, ce_hour} !== 3'b000) begin bad++; $display("FAIL reset_ce got=%b exp=000", {ce_sec, ce_min, ce_hour}); end
        total++; if (sec_clr !== 1'b0) begin bad++; $display("FAIL reset_secclr got=%b exp=0", sec_clr); end
        glob_rst = 1'b0;
        cyc();
    endtask

    task automatic test_run();
        tick_1hz = 1'b1; #1;
        total++; if ({ce_sec, ce_min, ce_hour} !== 3'b100) begin bad++; $display("FAIL run_tick got=%b exp=100", {ce_sec, ce_min, ce_hour}); end
        tick_1hz = 1'b0; sec_carry = 1'b1; #1;
        total++; if ({ce_sec, ce_min, ce_hour} !== 3'b010) begin bad++; $display("FAIL run_seccarry got=%b exp=010", {ce_sec, ce_min, ce_hour}); end
        sec_carry = 1'b0; min_carry = 1'b1; #1;
        total++; if ({ce_sec, ce_min, ce_hour} !== 3'b001) begin bad++; $display("FAIL run_mincarry got=%b exp=001", {ce_sec, ce_min, ce_hour}); end
        min_carry = 1'b0;
        cyc();
    endtask

    task automatic test_fsm();
        logic [1:0] exp_m [4] = '{2'b01, 2'b10, 2'b11, 2'b00};
        logic [1:0] prev = 2'b00;
        for (int i = 0; i < 4; i++) begin
            btn_mode = 1'b1;
            cyc();
            total++; if (mode !== prev) begin bad++; $display("FAIL fsm_early%0d got=%b exp=%b", i, mode, prev); end
            btn_mode = 1'b0;
            cyc();
            total++; if (mode !== exp_m[i]) begin bad++; $display("FAIL fsm_step%0d got=%b exp=%b", i, mode, exp_m[i]); end
            prev = exp_m[i];
        end
    endtask

    task automatic test_set();
        int n_min = 0, n_hour = 0, n_clr = 0, n_ce = 0;
        press_mode();
        press_mode();
        total++; if (mode !== 2'b10) begin bad++; $display("FAIL set_modemin got=%b exp=10", mode); end
        sec_carry = 1'b1; min_carry = 1'b1; #1;
        total++; if ({ce_min, ce_hour} !== 2'b00) begin bad++; $display("FAIL set_carry_ignored got=%b exp=00", {ce_min, ce_hour}); end
        sec_carry = 1'b0; min_carry = 1'b0;
        for (int p = 0; p < 3; p++) begin
            btn_inc = 1'b1;
            for (int k = 0; k < 3; k++) begin cyc(); n_min += int'(ce_min); n_hour += int'(ce_hour); end
            btn_inc = 1'b0;
            for (int k = 0; k < 2; k++) begin cyc(); n_min += int'(ce_min); n_hour += int'(ce_hour); end
        end
        total++; if (n_min != 3) begin bad++; $display("FAIL set_min_pulses got=%0d exp=3", n_min); end
        total++; if (n_hour != 0) begin bad++; $display("FAIL set_min_nohour got=%0d exp=0", n_hour); end
        press_mode();
        total++; if (mode !== 2'b11) begin bad++; $display("FAIL set_modesec got=%b exp=11", mode); end
        btn_inc = 1'b1;
        for (int k = 0; k < 3; k++) begin cyc(); n_clr += int'(sec_clr); n_ce += int'(ce_sec | ce_min | ce_hour); end
        btn_inc = 1'b0;
        for (int k = 0; k < 2; k++) begin cyc(); n_clr += int'(sec_clr); n_ce += int'(ce_sec | ce_min | ce_hour); end
        total++; if (n_clr != 1) begin bad++; $display("FAIL set_secclr got=%0d exp=1", n_clr); end
        total++; if (n_ce != 0) begin bad++; $display("FAIL set_sec_noce got=%0d exp=0", n_ce); end
        press_mode();
        total++; if (mode !== 2'b00) begin bad++; $display("FAIL set_back_run got=%b exp=00", mode); end
    endtask

    task automatic test_simultaneous();
        press_mode();
        btn_mode = 1'b1; btn_inc = 1'b1;
        cyc();
        total++; if (ce_hour !== 1'b1) begin bad++; $display("FAIL simul_cehour got=%b exp=1", ce_hour); end
        btn_mode = 1'b0; btn_inc = 1'b0;
        cyc();
        total++; if (mode !== 2'b10) begin bad++; $display("FAIL simul_mode got=%b exp=10", mode); end
        total++; if (ce_min !== 1'b0) begin bad++; $display("FAIL simul_nomin got=%b exp=0", ce_min); end
        press_mode();
        press_mode();
    endtask

    task automatic test_timeout();
        press_mode();
        for (int t = 0; t < 3; t++) begin
            cyc();
            tick_1hz = 1'b1; #1;
            total++; if (mode !== 2'b01 || ce_sec !== 1'b0) begin bad++; $display("FAIL tmo_before%0d got=%b/%b exp=01/0", t, mode, ce_sec); end
            cyc();
            tick_1hz = 1'b0;
        end
        total++; if (mode !== 2'b00) begin bad++; $display("FAIL tmo_expire got=%b exp=00", mode); end
        press_mode();
        for (int t = 0; t < 5; t++) begin
            if (t == 2) begin
                btn_inc = 1'b1; cyc(); btn_inc = 1'b0; cyc();
            end
            tick_1hz = 1'b1;
            cyc();
            tick_1hz = 1'b0;
            if (t < 4) begin
                total++; if (mode !== 2'b01) begin bad++; $display("FAIL tmo_restart%0d got=%b exp=01", t, mode); end
            end
            cyc();
        end
        total++; if (mode !== 2'b00) begin bad++; $display("FAIL tmo_restart_expire got=%b exp=00", mode); end
    endtask

    task automatic test_blink();
        logic [2:0] exp_b;
        total++; if (blank !== 3'b000) begin bad++; $display("FAIL blink_run got=%b exp=000", blank); end
        press_mode();
        press_mode();
        for (int j = 0; j < 16; j++) begin
            exp_b = (((j / 4) % 2) == 1) ? 3'b010 : 3'b000;
            total++; if (blank !== exp_b) begin bad++; $display("FAIL blink_min%0d got=%b exp=%b", j, blank, exp_b); end
            cyc();
        end
        press_mode();
        total++; if (blank !== 3'b000) begin bad++; $display("FAIL blink_sec_start got=%b exp=000", blank); end
        for (int j = 0; j < 4; j++) cyc();
        total++; if (blank !== 3'b001) begin bad++; $display("FAIL blink_sec_on got=%b exp=001", blank); end
        press_mode();
        total++; if (blank !== 3'b000) begin bad++; $display("FAIL blink_back_run got=%b exp=000", blank); end
    endtask

    task automatic test_hold();
        int n = 0;
        int exp_n;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        press_mode();
        press_mode();
        btn_inc = 1'b1;
        for (int k = 0; k < 20; k++) begin cyc(); n += int'(ce_min); end
        btn_inc = 1'b0;
        for (int k = 0; k < 6; k++) begin cyc(); n += int'(ce_min); end
        total++; if (n != exp_n) begin bad++; $display("FAIL hold_pulses got=%0d exp=%0d", n, exp_n); end
        press_mode();
        press_mode();
    endtask

    task automatic test_reset_midset();
        press_mode();
        press_mode();
        total++; if (mode !== 2'b10) begin bad++; $display("FAIL rstmid_pre got=%b exp=10", mode); end
        glob_rst = 1'b1;
        cyc();
        glob_rst = 1'b0;
        total++; if (mode !== 2'b00 || blank !== 3'b000) begin bad++; $display("FAIL rstmid_post got=%b/%b exp=00/000", mode, blank); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_run();
        test_fsm();
        test_set();
        test_simultaneous();
        test_timeout();
        test_blink();
        test_hold();
        test_reset_midset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule
